ac97_codec_model: RTL and testbench
===================================

# ac97_codec_model

Codec-side (responder) end of the AC97 serial link: consumes the controller's sync and output bitstream, and produces the codec's input bitstream. It decodes slot 0 tags, command address/data (slots 1/2) and PCM out (slots 3/4), and maintains a small mixer register file. Read responses go out in slots 1/2 of the following frame, and capture PCM goes out in slots 3/4. It is used as a bench/loopback partner for the AC97 controller and as the codec model in board-level simulation.

## Interface
Parameters:
- READY_FRAMES, 2, complete frames after reset release before the codec-ready tag asserts.

Ports:
- ac97_bit_clock  in  1  bit clock (12.288 MHz); only clock; all logic on rising edge.
- audio_reset_b  in  1  asynchronous, active-low reset.
- ac97_synch  in  1  frame sync from controller.
- ac97_sdata_out  in  1  controller→codec serial data.
- ac97_sdata_in  out  1  codec→controller serial data, registered.
- pcm_in_left, pcm_in_right  in  20  capture samples sent in slots 3/4.
- pcm_out_left, pcm_out_right  out  20  last received playback samples.
- pcm_out_valid  out  1  one-cycle pulse when a new valid left sample is received.
- codec_ready  out  1  mirrors slot-0 bit 15.
- headphone_vol  out  16  current value of register 0x04.
- record_select  out  16  current value of register 0x1A.

## Operation
- Sync detect: the block registers ac97_synch into sync_d. Edge index e=0 is a rising edge where ac97_synch=1 and sync_d=0. bit_cnt is set to 1 there, then increments by 1 per edge and saturates at 255. With no new sync, the block drives 0 while saturated.
- Transmit: at edge e the block drives frame bit e (MSB-first, slot 0 bits 15..0 at e=0..15, then 20-bit slots). e=0 uses the sync-detect edge directly.
- Receive: ac97_sdata_out is sampled at rising edges; bit e-1 is captured at edge e. Capture edges:
  - slot 0 tags: 1..16
  - slot 1: 17..36
  - slot 2: 37..56
  - slot 3: 57..76
  - slot 4: 77..96
- Command decode at edge 57: the command is valid if tag bits 14 and 13 are both 1.
  - Slot 1 bit 19=1: read of index slot1[18:12]. The block latches a pending response {index, regdata}.
  - Slot 1 bit 19=0: write of slot2[19:4] to that index, committed at edge 57.
- Register file, with reset defaults:
  - 0x02=0x8000, 0x04=0x8000, 0x0A=0x0000, 0x0E=0x8008, 0x18=0x8808, 0x1A=0x0000, 0x1C=0x8000, 0x20=0x0000: read/write.
  - 0x26=0x000F, 0x7C=0x4144, 0x7E=0x5370: read-only; writes ignored.
  - Any write to 0x00 restores all defaults; reads of 0x00 return 0x0000.
  - Unimplemented indices read 0x0000; writes to them are ignored.
- Outgoing slot 0 when codec ready:
  - bit 15=1.
  - bits 14/13=1 iff a response is pending.
  - bits 12/11=1.
  - others 0.
- Outgoing slots 1/2: slot1={1'b0, index, 12'h000}, slot2={data, 4'h0}. The pending flag clears at e=0 of the frame that transmits it. With no pending response, slots 1/2 are zero.
- Outgoing slots 3/4: pcm_in_left/right, latched at e=0.
- Codec readiness: before codec_ready, the whole outgoing frame is 0 and received commands are ignored. codec_ready asserts at e=0 of the (READY_FRAMES+1)th sync-detect after reset release.
- Playback path:
  - At edge 97, if received tag bit 12=1, pcm_out_left takes the slot-3 word and pcm_out_valid pulses for exactly one cycle.
  - If tag bit 11=1, pcm_out_right takes the slot-4 word at the same edge.

## Timing
- Reset (async, any time, including mid-frame) forces:
  - ac97_sdata_in=0, pcm_out_*=0, pcm_out_valid=0, codec_ready=0.
  - Registers to defaults, pending flag cleared, bit_cnt=255, sync_d=0.
- After reset the block waits for the next sync rise before doing anything.
- Read latency: a request in frame N is answered in frame N+1 slots 1/2. A second read in frame N+1 overwrites the pending response for frame N+2.
- A sync rise arriving before bit_cnt reaches 255 restarts the frame at e=0; the partial frame's command and PCM are discarded.
- Sync held high: only the rising edge counts.

## Test plan
- Reset, then 3 frames with READY_FRAMES=2: frames 1–2 ac97_sdata_in all 0; frame 3 slot 0 = 0x9800 (ready, slots 3/4 valid).
- Write 0x04 ← 0x0505 (addr 0x04, tags 1/2 set): headphone_vol=0x0505 after edge 57. A following read of 0x84 returns slot1=0x04000, slot2=0x05050, tag 0xF800.
- Read 0xFC: next frame slot2=0x41440. Write 0x7C ← 0x1234, then read again: still 0x4144.
- Slot-3 data 0xABCDE with tag bit 12: pcm_out_left=0xABCDE and a single-cycle pcm_out_valid at edge 97. With tag bit 12 clear, no pulse.
- pcm_in_left=0x12345: controller-side deserialized slot 3 = 0x12345. Write 0x00, then read 0x84: returns 0x8000.
- Assert audio_reset_b low at e=40 with a write in flight: write not committed, outputs 0 immediately, codec_ready=0 until READY_FRAMES frames later.

Source files
------------

// File: rtl/ac97_codec_model.sv
// Codec-side responder of an AC97 link: decodes tags, commands and playback PCM
// from the controller, keeps a small mixer register file and returns reads and capture PCM.
module ac97_codec_model #(
  parameter int READY_FRAMES = 2
) (
  input  logic        ac97_bit_clock,
  input  logic        audio_reset_b,
  input  logic        ac97_synch,
  input  logic        ac97_sdata_out,
  output logic        ac97_sdata_in,
  input  logic [19:0] pcm_in_left,
  input  logic [19:0] pcm_in_right,
  output logic [19:0] pcm_out_left,
  output logic [19:0] pcm_out_right,
  output logic        pcm_out_valid,
  output logic        codec_ready,
  output logic [15:0] headphone_vol,
  output logic [15:0] record_select
);

  localparam logic [15:0] DEF_02 = 16'h8000;
  localparam logic [15:0] DEF_04 = 16'h8000;
  localparam logic [15:0] DEF_0A = 16'h0000;
  localparam logic [15:0] DEF_0E = 16'h8008;
  localparam logic [15:0] DEF_18 = 16'h8808;
  localparam logic [15:0] DEF_1A = 16'h0000;
  localparam logic [15:0] DEF_1C = 16'h8000;
  localparam logic [15:0] DEF_20 = 16'h0000;

  logic        sync_d;
  logic        sync_rise;
  logic [7:0]  bit_cnt;
  logic [15:0] sync_seen;
  logic        ready_now;
  logic [19:0] rx_sh;
  logic        tag_cmd;
  logic        tag_left;
  logic        tag_right;
  logic [7:0]  slot1_hi;
  logic [19:0] rx_slot3;
  logic        pending;
  logic [6:0]  resp_idx;
  logic [15:0] resp_data;
  logic [95:0] tx_sh;
  logic [95:0] frame_live;

  logic [15:0] reg_02, reg_04, reg_0a, reg_0e, reg_18, reg_1a, reg_1c, reg_20;

  logic        cmd_fire;
  logic        cmd_read;
  logic        cmd_write;
  logic [6:0]  cmd_idx;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  assign sync_rise = ac97_synch & ~sync_d;
  assign ready_now = codec_ready | (sync_rise & (sync_seen == 16'(READY_FRAMES)));

  // Commands are acted on at edge 57, when slot 2 has just finished arriving in rx_sh.
  assign cmd_fire  = ~sync_rise && (bit_cnt == 8'd57) && codec_ready && tag_cmd;
  assign cmd_read  = cmd_fire & slot1_hi[7];
  assign cmd_write = cmd_fire & ~slot1_hi[7];
  assign cmd_idx   = slot1_hi[6:0];
  assign wr_data   = rx_sh[19:4];

  assign headphone_vol = reg_04;
  assign record_select = reg_1a;

  always_comb begin
    rd_data = 16'h0000;
    case (cmd_idx)
      7'h02:   rd_data = reg_02;
      7'h04:   rd_data = reg_04;
      7'h0A:   rd_data = reg_0a;
      7'h0E:   rd_data = reg_0e;
      7'h18:   rd_data = reg_18;
      7'h1A:   rd_data = reg_1a;
      7'h1C:   rd_data = reg_1c;
      7'h20:   rd_data = reg_20;
      7'h26:   rd_data = 16'h000F;
      7'h7C:   rd_data = 16'h4144;
      7'h7E:   rd_data = 16'h5370;
      default: rd_data = 16'h0000;
    endcase
  end

  // Outgoing slots 0..4, built from live state at the sync-detect edge.
  always_comb begin
    frame_live = '0;
    if (ready_now) begin
      frame_live[95:80] = {1'b1, pending, pending, 2'b11, 11'h000};
      frame_live[79:60] = pending ? {1'b0, resp_idx, 12'h000} : 20'h00000;
      frame_live[59:40] = pending ? {resp_data, 4'h0} : 20'h00000;
      frame_live[39:20] = pcm_in_left;
      frame_live[19:0]  = pcm_in_right;
    end
  end

  always_ff @(posedge ac97_bit_clock or negedge audio_reset_b) begin
    if (!audio_reset_b) begin
      reg_02 <= DEF_02;
      reg_04 <= DEF_04;
      reg_0a <= DEF_0A;
      reg_0e <= DEF_0E;
      reg_18 <= DEF_18;
      reg_1a <= DEF_1A;
      reg_1c <= DEF_1C;
      reg_20 <= DEF_20;
    end else if (cmd_write && (cmd_idx == 7'h00)) begin
      reg_02 <= DEF_02;
      reg_04 <= DEF_04;
      reg_0a <= DEF_0A;
      reg_0e <= DEF_0E;
      reg_18 <= DEF_18;
      reg_1a <= DEF_1A;
      reg_1c <= DEF_1C;
      reg_20 <= DEF_20;
    end else if (cmd_write) begin
      case (cmd_idx)
        7'h02:   reg_02 <= wr_data;
        7'h04:   reg_04 <= wr_data;
        7'h0A:   reg_0a <= wr_data;
        7'h0E:   reg_0e <= wr_data;
        7'h18:   reg_18 <= wr_data;
        7'h1A:   reg_1a <= wr_data;
        7'h1C:   reg_1c <= wr_data;
        7'h20:   reg_20 <= wr_data;
        default: ;
      endcase
    end
  end

  // pcm_out_valid is a one-cycle strobe with no back-pressure: the consumer must
  // take pcm_out_left in the cycle it is high.
  always_ff @(posedge ac97_bit_clock or negedge audio_reset_b) begin
    if (!audio_reset_b) begin
      sync_d        <= 1'b0;
      bit_cnt       <= 8'hFF;
      sync_seen     <= 16'h0000;
      codec_ready   <= 1'b0;
      ac97_sdata_in <= 1'b0;
      tx_sh         <= '0;
      rx_sh         <= 20'h00000;
      tag_cmd       <= 1'b0;
      tag_left      <= 1'b0;
      tag_right     <= 1'b0;
      slot1_hi      <= 8'h00;
      rx_slot3      <= 20'h00000;
      pending       <= 1'b0;
      resp_idx      <= 7'h00;
      resp_data     <= 16'h0000;
      pcm_out_left  <= 20'h00000;
      pcm_out_right <= 20'h00000;
      pcm_out_valid <= 1'b0;
    end else begin
      sync_d        <= ac97_synch;
      rx_sh         <= {rx_sh[18:0], ac97_sdata_out};
      pcm_out_valid <= 1'b0;
      if (sync_rise) begin
        bit_cnt       <= 8'd1;
        ac97_sdata_in <= frame_live[95];
        tx_sh         <= {frame_live[94:0], 1'b0};
        pending       <= 1'b0;
        if (!codec_ready) begin
          if (sync_seen == 16'(READY_FRAMES)) codec_ready <= 1'b1;
          else                                 sync_seen   <= sync_seen + 16'd1;
        end
      end else begin
        bit_cnt       <= (bit_cnt == 8'hFF) ? 8'hFF : bit_cnt + 8'd1;
        ac97_sdata_in <= tx_sh[95];
        tx_sh         <= {tx_sh[94:0], 1'b0};
        case (bit_cnt)
          8'd17: begin
            tag_cmd   <= rx_sh[14] & rx_sh[13];
            tag_left  <= rx_sh[12];
            tag_right <= rx_sh[11];
          end
          8'd37: slot1_hi <= rx_sh[19:12];
          8'd57: begin
            if (cmd_read) begin
              pending   <= 1'b1;
              resp_idx  <= cmd_idx;
              resp_data <= rd_data;
            end
          end
          8'd77: rx_slot3 <= rx_sh;
          8'd97: begin
            if (tag_left) begin
              pcm_out_left  <= rx_slot3;
              pcm_out_valid <= 1'b1;
            end
            if (tag_right) pcm_out_right <= rx_sh;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac97_codec_model.sv
// Controller-side bench for ac97_codec_model: plays whole frames from a vector
// table, deserialises the codec's reply frame and compares against hand-computed values.
module tb_ac97_codec_model;

  logic        ac97_bit_clock = 1'b0;
  logic        audio_reset_b  = 1'b0;
  logic        ac97_synch     = 1'b0;
  logic        ac97_sdata_out = 1'b0;
  logic [19:0] pcm_in_left    = 20'h0;
  logic [19:0] pcm_in_right   = 20'h0;
  logic        ac97_sdata_in;
  logic [19:0] pcm_out_left;
  logic [19:0] pcm_out_right;
  logic        pcm_out_valid;
  logic        codec_ready;
  logic [15:0] headphone_vol;
  logic [15:0] record_select;

  ac97_codec_model #(.READY_FRAMES(2)) dut (
    .ac97_bit_clock(ac97_bit_clock),
    .audio_reset_b (audio_reset_b),
    .ac97_synch    (ac97_synch),
    .ac97_sdata_out(ac97_sdata_out),
    .ac97_sdata_in (ac97_sdata_in),
    .pcm_in_left   (pcm_in_left),
    .pcm_in_right  (pcm_in_right),
    .pcm_out_left  (pcm_out_left),
    .pcm_out_right (pcm_out_right),
    .pcm_out_valid (pcm_out_valid),
    .codec_ready   (codec_ready),
    .headphone_vol (headphone_vol),
    .record_select (record_select)
  );

  // clock / reset
  always #5 ac97_bit_clock = ~ac97_bit_clock;

  typedef struct {
    logic [15:0] tag;
    logic [19:0] s1, s2, s3, s4;
    logic [19:0] pin_l, pin_r;
    logic [15:0] e_tag;
    logic [19:0] e_s1, e_s2, e_s3, e_s4;
    logic        e_ready;
    logic [15:0] e_hp, e_rs;
    logic [19:0] e_pl, e_pr;
    int          e_vcnt;
    int          e_vedge;
  } vec_t;

  vec_t        vecs[16];
  vec_t        hv;
  logic [95:0] rx_frame;
  logic [19:0] exp_q[$];
  int          tail_ones, vcnt, vedge;
  int          n_vec, n_cmp, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver: one frame from the controller side, capturing the codec's reply.
  task automatic run_frame(input vec_t v, input int rst_at, input int len, input int sync_len);
    logic [95:0] tx;
    tx = {v.tag, v.s1, v.s2, v.s3, v.s4};
    pcm_in_left  = v.pin_l;
    pcm_in_right = v.pin_r;
    rx_frame  = '0;
    tail_ones = 0;
    vcnt      = 0;
    vedge     = -1;
    for (int e = 0; e < len; e++) begin
      @(negedge ac97_bit_clock);
      ac97_synch     = (e < sync_len);
      ac97_sdata_out = (e >= 1 && e <= 96) ? tx[96-e] : 1'b0;
      if (rst_at >= 0 && e == rst_at + 2) audio_reset_b = 1'b1;
      @(posedge ac97_bit_clock);
      #1;
      if (e < 96) rx_frame[95-e] = ac97_sdata_in;
      else if (ac97_sdata_in) tail_ones++;
      if (pcm_out_valid) begin
        vcnt++;
        if (vedge < 0) vedge = e;
      end
      if (e == rst_at) begin
        audio_reset_b = 1'b0;
        #1;
        chk("rst_sdata_in", {31'h0, ac97_sdata_in}, 32'h0);
        chk("rst_ready",    {31'h0, codec_ready},   32'h0);
        chk("rst_valid",    {31'h0, pcm_out_valid}, 32'h0);
        chk("rst_pcm_left", {12'h0, pcm_out_left},  32'h0);
        chk("rst_pcm_right",{12'h0, pcm_out_right}, 32'h0);
        chk("rst_hp",       {16'h0, headphone_vol}, 32'h8000);
      end
    end
  endtask

  // Scoreboard: slot words go through the expected queue, then state checks.
  task automatic check_vec(input vec_t v, input string id);
    logic [19:0] got;
    exp_q.push_back({4'h0, v.e_tag});
    exp_q.push_back(v.e_s1);
    exp_q.push_back(v.e_s2);
    exp_q.push_back(v.e_s3);
    exp_q.push_back(v.e_s4);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) got = {4'h0, rx_frame[95:80]};
      else        got = rx_frame[79-20*(i-1) -: 20];
      chk($sformatf("%s_slot%0d", id, i), {12'h0, got}, {12'h0, exp_q.pop_front()});
    end
    chk({id, "_tail"},  tail_ones, 0);
    chk({id, "_ready"}, {31'h0, codec_ready}, {31'h0, v.e_ready});
    chk({id, "_hp"},    {16'h0, headphone_vol}, {16'h0, v.e_hp});
    chk({id, "_rs"},    {16'h0, record_select}, {16'h0, v.e_rs});
    chk({id, "_pl"},    {12'h0, pcm_out_left},  {12'h0, v.e_pl});
    chk({id, "_pr"},    {12'h0, pcm_out_right}, {12'h0, v.e_pr});
    chk({id, "_vcnt"},  vcnt,  v.e_vcnt);
    chk({id, "_vedge"}, vedge, v.e_vedge);
    n_vec++;
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_fail = 0;
    //            tag       s1        s2        s3        s4        pin_l     pin_r     e_tag     e_s1      e_s2      e_s3      e_s4      rdy   hp        rs        pl        pr     vcnt vedge
    vecs[0]  = '{16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h12345, 20'h6789A, 16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 1'b0, 16'h8000, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    vecs[1]  = '{16'hE000, 20'h04000, 20'h11110, 20'h00000, 20'h00000, 20'h12345, 20'h6789A, 16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 1'b0, 16'h8000, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    vecs[2]  = '{16'hE000, 20'h04000, 20'h05050, 20'h00000, 20'h00000, 20'h12345, 20'h6789A, 16'h9800, 20'h00000, 20'h00000, 20'h12345, 20'h6789A, 1'b1, 16'h0505, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    vecs[3]  = '{16'hE000, 20'h84000, 20'h00000, 20'h00000, 20'h00000, 20'h0ABCD, 20'hFFFFF, 16'h9800, 20'h00000, 20'h00000, 20'h0ABCD, 20'hFFFFF, 1'b1, 16'h0505, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    vecs[4]  = '{16'hE000, 20'hFC000, 20'h00000, 20'h00000, 20'h00000, 20'h00001, 20'h80000, 16'hF800, 20'h04000, 20'h05050, 20'h00001, 20'h80000, 1'b1, 16'h0505, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    vecs[5]  = '{16'hE000, 20'h7C000, 20'h12340, 20'h00000, 20'h00000, 20'h11111, 20'h22222, 16'hF800, 20'h7C000, 20'h41440, 20'h11111, 20'h22222, 1'b1, 16'h0505, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    vecs[6]  = '{16'hE000, 20'hFC000, 20'h00000, 20'h00000, 20'h00000, 20'h33333, 20'h44444, 16'h9800, 20'h00000, 20'h00000, 20'h33333, 20'h44444, 1'b1, 16'h0505, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    vecs[7]  = '{16'h9800, 20'h00000, 20'h00000, 20'hABCDE, 20'h13579, 20'h55555, 20'h66666, 16'hF800, 20'h7C000, 20'h41440, 20'h55555, 20'h66666, 1'b1, 16'h0505, 16'h0000, 20'hABCDE, 20'h13579, 1, 97};
    vecs[8]  = '{16'h8800, 20'h00000, 20'h00000, 20'h11111, 20'h22222, 20'h77777, 20'h88888, 16'h9800, 20'h00000, 20'h00000, 20'h77777, 20'h88888, 1'b1, 16'h0505, 16'h0000, 20'hABCDE, 20'h22222, 0, -1};
    vecs[9]  = '{16'hE000, 20'h1A000, 20'h03030, 20'h00000, 20'h00000, 20'h99999, 20'hAAAAA, 16'h9800, 20'h00000, 20'h00000, 20'h99999, 20'hAAAAA, 1'b1, 16'h0505, 16'h0303, 20'hABCDE, 20'h22222, 0, -1};
    vecs[10] = '{16'hE000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'hBBBBB, 20'hCCCCC, 16'h9800, 20'h00000, 20'h00000, 20'hBBBBB, 20'hCCCCC, 1'b1, 16'h8000, 16'h0000, 20'hABCDE, 20'h22222, 0, -1};
    vecs[11] = '{16'hE000, 20'h84000, 20'h00000, 20'h00000, 20'h00000, 20'hDDDDD, 20'hEEEEE, 16'h9800, 20'h00000, 20'h00000, 20'hDDDDD, 20'hEEEEE, 1'b1, 16'h8000, 16'h0000, 20'hABCDE, 20'h22222, 0, -1};
    vecs[12] = '{16'hE000, 20'hA6000, 20'h00000, 20'h00000, 20'h00000, 20'h10101, 20'h20202, 16'hF800, 20'h04000, 20'h80000, 20'h10101, 20'h20202, 1'b1, 16'h8000, 16'h0000, 20'hABCDE, 20'h22222, 0, -1};
    vecs[13] = '{16'hE000, 20'h80000, 20'h00000, 20'h00000, 20'h00000, 20'h30303, 20'h40404, 16'hF800, 20'h26000, 20'h000F0, 20'h30303, 20'h40404, 1'b1, 16'h8000, 16'h0000, 20'hABCDE, 20'h22222, 0, -1};
    vecs[14] = '{16'hE000, 20'h9E000, 20'h00000, 20'h00000, 20'h00000, 20'h50505, 20'h60606, 16'hF800, 20'h00000, 20'h00000, 20'h50505, 20'h60606, 1'b1, 16'h8000, 16'h0000, 20'hABCDE, 20'h22222, 0, -1};
    vecs[15] = '{16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h70707, 20'h80808, 16'hF800, 20'h1E000, 20'h00000, 20'h70707, 20'h80808, 1'b1, 16'h8000, 16'h0000, 20'hABCDE, 20'h22222, 0, -1};

    repeat (3) @(negedge ac97_bit_clock);
    #1;
    chk("reset_sdata_in", {31'h0, ac97_sdata_in}, 32'h0);
    chk("reset_ready",    {31'h0, codec_ready},   32'h0);
    chk("reset_hp",       {16'h0, headphone_vol}, 32'h8000);
    chk("reset_rs",       {16'h0, record_select}, 32'h0);
    audio_reset_b = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_frame(vecs[i], -1, 256, 16);
      check_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset at edge 40 with a write of 0x7777 to 0x04 in flight.
    hv = '{16'hE000, 20'h04000, 20'h77770, 20'h00000, 20'h00000, 20'h12345, 20'h6789A, 16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 1'b0, 16'h8000, 16'h0000, 20'h00000, 20'h00000, 0, -1};
    run_frame(hv, 40, 256, 16);
    chk("rst_frame_ready", {31'h0, codec_ready}, 32'h0);
    chk("rst_frame_hp",    {16'h0, headphone_vol}, 32'h8000);
    n_vec++;

    hv.tag = 16'h0000; hv.s1 = 20'h0; hv.s2 = 20'h0;
    run_frame(hv, -1, 256, 16);
    check_vec(hv, "post_rst1");
    hv.tag = 16'hE000; hv.s1 = 20'h04000; hv.s2 = 20'h66660;
    run_frame(hv, -1, 256, 16);
    check_vec(hv, "post_rst2");
    hv.tag = 16'h0000; hv.s1 = 20'h0; hv.s2 = 20'h0;
    hv.e_tag = 16'h9800; hv.e_s3 = 20'h12345; hv.e_s4 = 20'h6789A; hv.e_ready = 1'b1;
    run_frame(hv, -1, 256, 16);
    check_vec(hv, "post_rst3");

    // Partial frame carrying a write, cut short by an early sync; then a frame
    // with sync held high for 120 bits carrying left PCM only.
    hv.tag = 16'hE000; hv.s1 = 20'h04000; hv.s2 = 20'h44440;
    run_frame(hv, -1, 50, 16);
    hv = '{16'h9000, 20'h00000, 20'h00000, 20'h55555, 20'h99999, 20'hCAFE1, 20'h0BEEF, 16'h9800, 20'h00000, 20'h00000, 20'hCAFE1, 20'h0BEEF, 1'b1, 16'h8000, 16'h0000, 20'h55555, 20'h00000, 1, 97};
    run_frame(hv, -1, 256, 120);
    check_vec(hv, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
